// File: rtl/seq_mult_ctrl.sv
// Operand sequencer and result capture for a sequential multiplier (seq_mult), with a one-deep pending operand buffer.
// Latency: accept -> LOAD 1 edge, RUN from 2nd edge, result on the edge mult_rdy is first sampled high in RUN.
// Backpressure: in_ready = !pend_valid (registered only); result held in DONE until out_ready, blocking the next LOAD.
module seq_mult_ctrl #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic                 mult_start,
   output logic [WIDTH-1:0]     mult_a,
   output logic [WIDTH-1:0]     mult_b,
   input  logic [2*WIDTH-1:0]   mult_p,
   input  logic                 mult_rdy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic                 out_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 pend_valid_q, pend_valid_d;
   logic [WIDTH-1:0]     pend_a_q, pend_a_d;
   logic [WIDTH-1:0]     pend_b_q, pend_b_d;
   logic [WIDTH-1:0]     mult_a_q, mult_a_d;
   logic [WIDTH-1:0]     mult_b_q, mult_b_d;
   logic                 mult_start_q, mult_start_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]   out_p_q, out_p_d;
   logic                 out_err_q, out_err_d;

   logic                 accept;
   logic                 drain;

   // Input side: buffer is free exactly when nothing is pending (no path from out_ready).
   assign in_ready = !pend_valid_q;
   assign accept   = in_valid && !pend_valid_q;

   // Pending buffer: latch on accept, clear when the FSM launches the pair; a same-cycle accept wins.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_a_d     = pend_a_q;
      pend_b_d     = pend_b_q;
      if (drain) begin
         pend_valid_d = 1'b0;
      end
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_a_d     = in_a;
         pend_b_d     = in_b;
      end
   end

   // Sequencer next-state and registered outputs.
   always_comb begin
      state_d      = state_q;
      drain        = 1'b0;
      mult_a_d     = mult_a_q;
      mult_b_d     = mult_b_q;
      mult_start_d = 1'b0;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_p_d      = out_p_q;
      out_err_d    = out_err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pend_valid_q) begin
               drain        = 1'b1;
               mult_a_d     = pend_a_q;
               mult_b_d     = pend_b_q;
               mult_start_d = 1'b1;
               state_d      = ST_LOAD;
            end
         end

         ST_LOAD: begin
            // start pulse drops here; watchdog starts from zero on entry to RUN
            cnt_d   = '0;
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (cnt_q != CW'(TIMEOUT)) begin
               cnt_d = cnt_q + 1'b1;
            end
            // a done multiplier takes priority over an expiring watchdog
            if (mult_rdy) begin
               out_valid_d = 1'b1;
               out_p_d     = mult_p;
               out_err_d   = 1'b0;
               state_d     = ST_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               out_valid_d = 1'b1;
               out_p_d     = '0;
               out_err_d   = 1'b1;
               state_d     = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (pend_valid_q) begin
                  drain        = 1'b1;
                  mult_a_d     = pend_a_q;
                  mult_b_d     = pend_b_q;
                  mult_start_d = 1'b1;
                  state_d      = ST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any job and pending pair.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         pend_valid_q <= 1'b0;
         pend_a_q     <= '0;
         pend_b_q     <= '0;
         mult_a_q     <= '0;
         mult_b_q     <= '0;
         mult_start_q <= 1'b0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_p_q      <= '0;
         out_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_a_q     <= pend_a_d;
         pend_b_q     <= pend_b_d;
         mult_a_q     <= mult_a_d;
         mult_b_q     <= mult_b_d;
         mult_start_q <= mult_start_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_p_q      <= out_p_d;
         out_err_q    <= out_err_d;
      end
   end

   assign mult_start = mult_start_q;
   assign mult_a     = mult_a_q;
   assign mult_b     = mult_b_q;
   assign out_valid  = out_valid_q;
   assign out_p      = out_p_q;
   assign out_err    = out_err_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

   localparam int W  = 8;
   localparam int TO = 40;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    in_a, in_b;
   logic            mult_start;
   logic [W-1:0]    mult_a, mult_b;
   logic [2*W-1:0]  mult_p;
   logic            mult_rdy;
   logic            out_valid;
   logic            out_ready;
   logic [2*W-1:0]  out_p;
   logic            out_err;

   int n_vec = 0;
   int n_err = 0;

   seq_mult_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mult_start (mult_start),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_p     (mult_p),
      .mult_rdy   (mult_rdy),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .out_err    (out_err)
   );

   always #5 clk = ~clk;

   // Multiplier stub: rdy rises 2*W+1 edges after the start pulse is seen low again.
   logic        stuck = 1'b0;
   logic        sbusy;
   logic [4:0]  scnt;
   logic signed [2*W-1:0] ea, eb, prod;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sbusy <= 1'b0;
         scnt  <= '0;
      end else if (mult_start) begin
         sbusy <= 1'b1;
         scnt  <= '0;
      end else if (sbusy && scnt != 5'd17) begin
         scnt  <= scnt + 5'd1;
      end
   end
   assign ea       = {{W{mult_a[W-1]}}, mult_a};
   assign eb       = {{W{mult_b[W-1]}}, mult_b};
   assign prod     = ea * eb;
   assign mult_rdy = sbusy && (scnt == 5'd17) && !stuck;
   assign mult_p   = mult_rdy ? prod : 16'hDEAD;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one pair; returns #1 after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) check("send_timeout", 32'd1, 32'd0);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Poll out_valid after each edge; edges = number of edges until seen (0 on expiry).
   task automatic wait_result(output logic [2*W-1:0] p, output logic e, output int edges);
      edges = 0;
      p     = '0;
      e     = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            edges = k;
            p     = out_p;
            e     = out_err;
            break;
         end
      end
      if (edges == 0) check("result_timeout", 32'd1, 32'd0);
   endtask

   logic [2*W-1:0] rp;
   logic           re;
   int             redges;
   int             seen;

   initial begin
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  32'(in_ready),   32'd1);
      check("rst_out_valid", 32'(out_valid),  32'd0);
      check("rst_start",     32'(mult_start), 32'd0);
      check("rst_out_p",     32'(out_p),      32'd0);
      check("rst_out_err",   32'(out_err),    32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 3 * 5, with latency from accept edge
      send(8'd3, 8'd5);
      wait_result(rp, re, redges);
      check("t1_p",       32'(rp),     32'h000F);
      check("t1_err",     32'(re),     32'd0);
      check("t1_latency", 32'(redges), 32'd20);
      @(posedge clk);
      #1;
      check("t1_consumed", 32'(out_valid), 32'd0);

      // three pairs back to back, results in order
      fork
         begin
            send(8'd3, 8'd1);
            send(8'hFE, 8'h03);
            check("b2b_in_ready_low", 32'(in_ready), 32'd0);
            send(8'h80, 8'h80);
         end
         begin
            wait_result(rp, re, redges);
            check("b2b_r0", 32'(rp), 32'h0003);
            wait_result(rp, re, redges);
            check("b2b_r1", 32'(rp), 32'hFFFA);
            wait_result(rp, re, redges);
            check("b2b_r2", 32'(rp), 32'h4000);
            check("b2b_r2_err", 32'(re), 32'd0);
         end
      join
      repeat (3) @(posedge clk);

      // hold in DONE with out_ready low, pending pair waiting
      out_ready = 1'b0;
      send(8'd2, 8'd7);
      wait_result(rp, re, redges);
      check("hold_p0", 32'(rp), 32'h000E);
      send(8'd5, 8'hFF);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("hold_valid", 32'(out_valid),  32'd1);
         check("hold_p",     32'(out_p),      32'h000E);
         check("hold_start", 32'(mult_start), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hs_valid_drop", 32'(out_valid),  32'd0);
      check("hs_direct_load", 32'(mult_start), 32'd1);
      check("hs_mult_a",     32'(mult_a),     32'h05);
      wait_result(rp, re, redges);
      check("hold_p1", 32'(rp), 32'hFFFB);
      @(posedge clk);

      // watchdog: stuck multiplier, error TO edges after entering RUN
      stuck = 1'b1;
      send(8'd9, 8'd9);
      wait_result(rp, re, redges);
      check("to_err",     32'(re),     32'd1);
      check("to_p",       32'(rp),     32'h0000);
      check("to_latency", 32'(redges), 32'(TO + 2));
      @(posedge clk);
      stuck = 1'b0;

      // asynchronous reset mid-RUN with a pending pair
      send(8'd4, 8'd4);
      send(8'd6, 8'd6);
      repeat (5) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("ar_in_ready",  32'(in_ready),   32'd1);
      check("ar_out_valid", 32'(out_valid),  32'd0);
      check("ar_start",     32'(mult_start), 32'd0);
      check("ar_mult_a",    32'(mult_a),     32'd0);
      check("ar_out_p",     32'(out_p),      32'd0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || mult_start) seen++;
      end
      check("ar_no_result", 32'(seen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
